// File: rtl/fetch_pc_unit.sv
// Fetch-stage PC generator and IF/ID pipeline register with a boot hold-off FSM.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_pc_unit #(
    parameter int          INDEX_WIDTH = 12,
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          BOOT_CYCLES = 2
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          stall_i,
    input  logic [1:0]                    IF_PCnext_sel_i,
    input  logic                          IF_flush_i,
    input  logic                          IF_btb_hit_i,
    input  logic [31:0]                   IF_btb_rd_target_i,
    input  logic [31:0]                   EXMEM_PCplus4_i,
    input  logic [31:0]                   EXMEM_br_target_i,
    input  logic [31:0]                   imem_rdata_i,
    output logic [31:0]                   IF_PC_o,
    output logic [INDEX_WIDTH-1:0]        IF_btb_rd_index_o,
    output logic [32-INDEX_WIDTH-2-1:0]   IF_PC_tag_o,
    output logic                          ID_valid_o,
    output logic [31:0]                   ID_PC_o,
    output logic [31:0]                   ID_instr_o,
    output logic                          ID_btb_hit_o,
    output logic [31:0]                   ID_pred_target_o,
    output logic [31:0]                   fetch_cnt_o,
    output logic [31:0]                   flush_cnt_o
);

    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam int          CNT_W   = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] BOOT_LOAD = CNT_W'(BOOT_CYCLES);

    typedef enum logic {BOOT, RUN} state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] boot_cnt, boot_cnt_next;
    logic             do_flush, do_fetch;
    logic [31:0]      pc_plus4, pc_next;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state    <= BOOT;
            boot_cnt <= BOOT_LOAD;
        end else begin
            state    <= state_next;
            boot_cnt <= boot_cnt_next;
        end
    end

    // NOTE: every comb output gets a default first so no latch is inferred.
    always_comb begin
        state_next    = state;
        boot_cnt_next = boot_cnt;
        case (state)
            BOOT: begin
                if (boot_cnt <= CNT_W'(1)) state_next = RUN;
                else                       boot_cnt_next = boot_cnt - CNT_W'(1);
            end
            RUN:     state_next = RUN;
            default: state_next = BOOT;
        endcase
    end

    always_comb begin
        do_flush = (state == RUN) && IF_flush_i;
        do_fetch = (state == RUN) && !IF_flush_i && !stall_i;
    end

    assign pc_plus4 = IF_PC_o + 32'd4;

    always_comb begin
        case (IF_PCnext_sel_i)
            2'b00:   pc_next = pc_plus4;
            2'b01:   pc_next = EXMEM_PCplus4_i;
            2'b10:   pc_next = IF_btb_rd_target_i;
            default: pc_next = EXMEM_br_target_i;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            IF_PC_o          <= RESET_PC;
            ID_valid_o       <= 1'b0;
            ID_PC_o          <= 32'd0;
            ID_instr_o       <= NOP;
            ID_btb_hit_o     <= 1'b0;
            ID_pred_target_o <= 32'd0;
        end else if (do_flush) begin
            // ID_PC_o deliberately keeps its value across the bubble.
            IF_PC_o          <= pc_next;
            ID_valid_o       <= 1'b0;
            ID_instr_o       <= NOP;
            ID_btb_hit_o     <= 1'b0;
            ID_pred_target_o <= 32'd0;
        end else if (do_fetch) begin
            IF_PC_o          <= pc_next;
            ID_valid_o       <= 1'b1;
            ID_PC_o          <= IF_PC_o;
            ID_instr_o       <= imem_rdata_i;
            ID_btb_hit_o     <= IF_btb_hit_i;
            ID_pred_target_o <= (IF_PCnext_sel_i == 2'b10) ? IF_btb_rd_target_i : pc_plus4;
        end
    end

    assign IF_btb_rd_index_o = IF_PC_o[INDEX_WIDTH+1:2];
    assign IF_PC_tag_o       = IF_PC_o[31:INDEX_WIDTH+2];

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            fetch_cnt_o <= 32'd0;
            flush_cnt_o <= 32'd0;
        end else begin
            if (do_fetch && (fetch_cnt_o != 32'hFFFF_FFFF)) fetch_cnt_o <= fetch_cnt_o + 32'd1;
            if (do_flush && (flush_cnt_o != 32'hFFFF_FFFF)) flush_cnt_o <= flush_cnt_o + 32'd1;
        end
    end
`else
    assign fetch_cnt_o = 32'd0;
    assign flush_cnt_o = 32'd0;
`endif

endmodule

// File: doc/fetch_pc_unit.md
# fetch_pc_unit

Fetch-stage PC generator and IF/ID pipeline register. Sits directly downstream of the branch predictor. It consumes the predictor's next-PC select, BTB target and flush. It owns the architectural fetch PC and drives the instruction-memory address and the predictor's BTB read index and tag. It registers the fetched instruction together with its prediction metadata into the Decode stage.

## Interface
- `INDEX_WIDTH`, 12, BTB index width; tag width is `32-INDEX_WIDTH-2`.
- `RESET_PC`, 32'h0000_0000, first fetch address after reset.
- `BOOT_CYCLES`, 2, cycles the PC is held at `RESET_PC` after reset release (≥1).

Ports:
- `clk_i` in 1: single clock, rising edge.
- `rst_i` in 1: reset, synchronous, active-low.
- `stall_i` in 1: hazard-unit hold of PC and IF/ID.
- `IF_PCnext_sel_i` in 2: 00 PC+4, 01 `EXMEM_PCplus4_i`, 10 `IF_btb_rd_target_i`, 11 `EXMEM_br_target_i`.
- `IF_flush_i` in 1: mispredict redirect; squash IF/ID.
- `IF_btb_hit_i` in 1: BTB hit for current `IF_PC_o`.
- `IF_btb_rd_target_i` in 32: BTB target for current `IF_PC_o`.
- `EXMEM_PCplus4_i` in 32: fall-through PC of the committing branch.
- `EXMEM_br_target_i` in 32: resolved target of the committing branch.
- `imem_rdata_i` in 32: instruction at `IF_PC_o`, combinational read.
- `IF_PC_o` out 32: current fetch PC (registered).
- `IF_btb_rd_index_o` out INDEX_WIDTH: `IF_PC_o[INDEX_WIDTH+1:2]`.
- `IF_PC_tag_o` out 32-INDEX_WIDTH-2: `IF_PC_o[31:INDEX_WIDTH+2]`.
- `ID_valid_o` out 1: IF/ID holds a real instruction.
- `ID_PC_o` out 32: PC of the IF/ID instruction.
- `ID_instr_o` out 32: IF/ID instruction; 32'h0000_0013 (NOP) when invalid.
- `ID_btb_hit_o` out 1: fetch-time BTB hit, carried to commit.
- `ID_pred_target_o` out 32: PC predicted to follow this instruction.
- `fetch_cnt_o` out 32: valid fetches (macro only).
- `flush_cnt_o` out 32: accepted flushes (macro only).

## Operation
- **FSM states.**
  - BOOT: entered on reset. A down-counter is loaded with `BOOT_CYCLES`. PC is held and `ID_valid_o` is 0. `stall_i` and `IF_flush_i` are ignored. When the counter reaches 1, the next state is RUN.
  - RUN: normal fetch. The FSM stays in RUN until reset.
- **Next PC (RUN).** The PC is selected by `IF_PCnext_sel_i`. PC+4 is computed modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
- **Priority per edge.** reset > BOOT > flush > stall > fetch.
- **Flush.**
  - PC loads the selected next PC, and `IF_PCnext_sel_i` is obeyed even if it is 00 or 10.
  - IF/ID loads a bubble: `ID_valid_o`=0, `ID_instr_o`=NOP, `ID_btb_hit_o`=0, `ID_pred_target_o`=0.
  - `ID_PC_o` holds its value.
  - Flush overrides a simultaneous stall.
  - Stages from ID/EX onward are squashed elsewhere.
- **Stall (no flush).** PC and all IF/ID fields hold.
- **Fetch.**
  - PC loads the selected next PC.
  - IF/ID loads: `ID_valid_o`=1, `ID_PC_o`=`IF_PC_o`, `ID_instr_o`=`imem_rdata_i`, `ID_btb_hit_o`=`IF_btb_hit_i`.
  - `ID_pred_target_o` = `IF_btb_rd_target_i` when sel=10, else `IF_PC_o`+4.
- **Reset values.**
  - `IF_PC_o`=`RESET_PC`.
  - `ID_valid_o`=0, `ID_PC_o`=0, `ID_instr_o`=NOP, `ID_btb_hit_o`=0, `ID_pred_target_o`=0.
  - Counters = 0, state = BOOT.
- **Reset mid-operation.** Any cycle with `rst_i`=0 discards in-flight state and restarts BOOT.

## Timing
- All outputs are registered except `IF_btb_rd_index_o` and `IF_PC_tag_o`, which are wire slices of `IF_PC_o`.
- IF→ID latency is 1 cycle. A redirect is visible on `IF_PC_o` on the edge after `IF_flush_i` is sampled high.
- After `rst_i` deasserts, the first valid fetch edge occurs after `BOOT_CYCLES` edges. `ID_valid_o` first rises `BOOT_CYCLES+1` edges after release.
- The select and flush inputs are combinational from the predictor and are sampled on the same edge. There is no internal combinational path from them to any output.

## Configuration
- `FETCH_PERF_CNT_EN`, when defined:
  - `fetch_cnt_o` increments on each fetch edge (RUN, no flush, no stall).
  - `flush_cnt_o` increments on each flush accepted in RUN.
  - Both counters saturate at 32'hFFFF_FFFF.
- When not defined: the counters are not built and both ports are tied to 0.

## Test plan
- Reset with `RESET_PC`=32'h100, `BOOT_CYCLES`=2, then release → `IF_PC_o` stays 0x100 for 2 edges, then steps 0x104, 0x108. `ID_valid_o` rises with `ID_PC_o`=0x100.
- In RUN at PC 0x200: sel=10, target 0x400, hit=1 → `IF_PC_o`=0x400. `ID_PC_o`=0x200, `ID_btb_hit_o`=1, `ID_pred_target_o`=0x400.
- Flush with sel=11, `EXMEM_br_target_i`=0x80, `stall_i`=1 → `IF_PC_o`=0x80, `ID_valid_o`=0, `ID_instr_o`=0x13. With the macro, `flush_cnt_o`=1.
- `stall_i`=1 for 3 cycles at PC 0x300 → `IF_PC_o` and all ID outputs are unchanged. `fetch_cnt_o` does not advance.
- PC 0xFFFF_FFFC with sel=00 → `IF_PC_o`=0 and `ID_pred_target_o`=0.
- `IF_flush_i`=1 during BOOT → ignored, PC stays `RESET_PC`. Asserting reset mid-RUN returns the unit to BOOT with all reset values.
